// File: rtl/instr_encoder_if.sv
// Bus bundle for instr_encoder: field-tuple input handshake and memory write port.
// slave is the encoder's view; master is the loader/memory-side view.
interface instr_encoder_if #(
  parameter int ADDR_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_opcode;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [31:0]       in_imm;
  logic [25:0]       in_target;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  in_valid, in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
    output in_ready,
    output mem_valid, mem_addr, mem_wdata,
    input  mem_ready
  );

  modport master (
    output in_valid, in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
    input  in_ready,
    input  mem_valid, mem_addr, mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs MIPS R/I/J fields into 32-bit words, queues them, and writes them to consecutive
// addresses. Optional ENC_RANGE_CHECK_EN rejects I-type immediates that do not fit 16 bits.
module instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_encoder_if.slave        bus,
  input  logic                  addr_clr,
  output logic [$clog2(DEPTH):0] count
`ifdef ENC_RANGE_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_e;

  fmt_e              w_fmt;
  logic [31:0]       w_word;
  logic              w_ready;
  logic              w_accept;
  logic              w_reject;
  logic              w_push;
  logic              w_pop;

  logic [31:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_addr;

  always_comb begin
    w_fmt = FMT_I;
    case (bus.in_opcode)
      6'h00:        w_fmt = FMT_R;
      6'h02, 6'h03: w_fmt = FMT_J;
      default:      w_fmt = FMT_I;
    endcase
  end

  always_comb begin
    w_word = '0;
    case (w_fmt)
      FMT_R:   w_word = {bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
      FMT_J:   w_word = {bus.in_opcode, bus.in_target};
      default: w_word = {bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
    endcase
  end

  // Ready looks only at registered occupancy, so a full FIFO refuses input even during a pop.
  assign w_ready  = (r_count < CNT_W'(DEPTH));
  assign w_accept = bus.in_valid && w_ready;

`ifdef ENC_RANGE_CHECK_EN
  logic r_err;

  assign w_reject = (w_fmt == FMT_I) && (bus.in_imm[31:16] != {16{bus.in_imm[15]}});
  assign err      = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_accept && w_reject;
  end
`else
  logic w_unused_imm;

  assign w_reject     = 1'b0;
  assign w_unused_imm = &{1'b0, bus.in_imm[31:16]};
`endif

  assign w_push = w_accept && !w_reject;
  assign w_pop  = (r_count != '0) && bus.mem_ready;

  // NOTE: storage is deliberately not reset; occupancy and pointers alone define valid data,
  // and the output mux below forces zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= BASE_ADDR;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      // Clear beats a same-cycle increment; the add wraps modulo 2^ADDR_W by design.
      if (addr_clr)   r_addr <= BASE_ADDR;
      else if (w_pop) r_addr <= r_addr + ADDR_W'(4);
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.mem_valid = (r_count != '0);
  assign bus.mem_wdata = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign bus.mem_addr  = r_addr;
  assign count         = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: default instance plus a small-address
// instance (ADDR_W=4, BASE_ADDR=8) to exercise address wrap.
module tb_instr_encoder;

  logic clk;
  logic rst_n;
  logic addr_clr_a;
  logic addr_clr_b;
  logic [2:0] count_a;
  logic [2:0] count_b;
`ifdef ENC_RANGE_CHECK_EN
  logic err_a;
  logic err_b;
`endif

  int n_checks = 0;
  int n_err    = 0;

  instr_encoder_if #(.ADDR_W(32)) ifc_a ();
  instr_encoder_if #(.ADDR_W(4))  ifc_b ();

  instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'd0)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifc_a.slave),
    .addr_clr (addr_clr_a),
    .count    (count_a)
`ifdef ENC_RANGE_CHECK_EN
    ,
    .err      (err_a)
`endif
  );

  instr_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(4'd8)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifc_b.slave),
    .addr_clr (addr_clr_b),
    .count    (count_b)
`ifdef ENC_RANGE_CHECK_EN
    ,
    .err      (err_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                       input logic [31:0] imm, input logic [25:0] tgt);
    ifc_a.in_opcode = op;
    ifc_a.in_rs     = rs;
    ifc_a.in_rt     = rt;
    ifc_a.in_rd     = rd;
    ifc_a.in_shamt  = sh;
    ifc_a.in_funct  = fn;
    ifc_a.in_imm    = imm;
    ifc_a.in_target = tgt;
    ifc_a.in_valid  = 1'b1;
  endtask

  // addi-style tuples used for the backpressure sequence and their hand-packed words
  logic [31:0] bp_imm  [5] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'hFFFF_FFFF};
  logic [31:0] bp_word [5] = '{32'h2022_0001, 32'h2022_0002, 32'h2022_0003, 32'h2022_0004, 32'h2022_FFFF};

  initial begin
    rst_n      = 1'b0;
    addr_clr_a = 1'b0;
    addr_clr_b = 1'b0;
    ifc_a.in_valid = 1'b0; ifc_a.mem_ready = 1'b0;
    ifc_a.in_opcode = '0; ifc_a.in_rs = '0; ifc_a.in_rt = '0; ifc_a.in_rd = '0;
    ifc_a.in_shamt = '0; ifc_a.in_funct = '0; ifc_a.in_imm = '0; ifc_a.in_target = '0;
    ifc_b.in_valid = 1'b0; ifc_b.mem_ready = 1'b0;
    ifc_b.in_opcode = '0; ifc_b.in_rs = '0; ifc_b.in_rt = '0; ifc_b.in_rd = '0;
    ifc_b.in_shamt = '0; ifc_b.in_funct = '0; ifc_b.in_imm = '0; ifc_b.in_target = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_count",     32'(count_a),         32'd0);
    check("rst_mem_valid", 32'(ifc_a.mem_valid), 32'd0);
    check("rst_mem_addr",  ifc_a.mem_addr,       32'd0);
    check("rst_mem_wdata", ifc_a.mem_wdata,      32'd0);
    check("rst_in_ready",  32'(ifc_a.in_ready),  32'd1);
    check("rst_addr_b",    32'(ifc_b.mem_addr),  32'd8);
`ifdef ENC_RANGE_CHECK_EN
    check("rst_err",       32'(err_a),           32'd0);
`endif
    rst_n = 1'b1;
    step();
    check("post_rst_ready", 32'(ifc_a.in_ready), 32'd1);

    // R-type add $8,$16,$18
    ifc_a.mem_ready = 1'b1;
    set_a(6'h00, 5'd16, 5'd18, 5'd8, 5'd0, 6'h20, 32'hDEAD_BEEF, 26'h3FF_FFFF);
    step();
    ifc_a.in_valid = 1'b0;
    check("r_valid", 32'(ifc_a.mem_valid), 32'd1);
    check("r_wdata", ifc_a.mem_wdata,      32'h0212_4020);
    check("r_addr",  ifc_a.mem_addr,       32'd0);
    step();
    check("r_drain_count", 32'(count_a),   32'd0);
    check("r_drain_addr",  ifc_a.mem_addr, 32'd4);
    addr_clr_a = 1'b1;
    step();
    addr_clr_a = 1'b0;
    check("clr_addr", ifc_a.mem_addr, 32'd0);

    // I-type then J-type back to back at full throughput
    set_a(6'h23, 5'd16, 5'd18, 5'd0, 5'd0, 6'h00, 32'h0, 26'h0);
    step();
    check("lw_wdata", ifc_a.mem_wdata, 32'h8E12_0000);
    check("lw_addr",  ifc_a.mem_addr,  32'd0);
    set_a(6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 32'hFFFF_FFFF, 26'h010_0000);
    step();
    ifc_a.in_valid = 1'b0;
    check("j_wdata", ifc_a.mem_wdata, 32'h0810_0000);
    check("j_addr",  ifc_a.mem_addr,  32'd4);
    check("j_count", 32'(count_a),    32'd1);
    step();
    check("ij_drain_addr", ifc_a.mem_addr, 32'd8);
    check("ij_drain_count", 32'(count_a),  32'd0);

    // Backpressure: fill, stall, then drain in order
    addr_clr_a = 1'b1;
    ifc_a.mem_ready = 1'b0;
    step();
    addr_clr_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_a(6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, bp_imm[k], 26'h0);
      step();
      check($sformatf("bp_fill_count%0d", k), 32'(count_a), 32'(k + 1));
    end
    check("bp_full_ready", 32'(ifc_a.in_ready), 32'd0);
    set_a(6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, bp_imm[4], 26'h0);
    step();
    step();
    check("bp_stall_count", 32'(count_a),        32'd4);
    check("bp_stall_ready", 32'(ifc_a.in_ready), 32'd0);
    check("bp_stall_addr",  ifc_a.mem_addr,      32'd0);
    check("bp_stall_wdata", ifc_a.mem_wdata,     bp_word[0]);
    ifc_a.mem_ready = 1'b1;
    step();
    check("bp_pop0_count", 32'(count_a),        32'd3);
    check("bp_pop0_ready", 32'(ifc_a.in_ready), 32'd1);
    check("bp_pop0_addr",  ifc_a.mem_addr,      32'd4);
    check("bp_pop0_wdata", ifc_a.mem_wdata,     bp_word[1]);
    step();
    ifc_a.in_valid = 1'b0;
    check("bp_pushpop_count", 32'(count_a),    32'd3);
    check("bp_pop1_addr",     ifc_a.mem_addr,  32'd8);
    check("bp_pop1_wdata",    ifc_a.mem_wdata, bp_word[2]);
    step();
    check("bp_pop2_addr",  ifc_a.mem_addr,  32'd12);
    check("bp_pop2_wdata", ifc_a.mem_wdata, bp_word[3]);
    step();
    check("bp_pop3_addr",  ifc_a.mem_addr,  32'd16);
    check("bp_pop3_wdata", ifc_a.mem_wdata, bp_word[4]);
    step();
    check("bp_empty_valid", 32'(ifc_a.mem_valid), 32'd0);
    check("bp_empty_addr",  ifc_a.mem_addr,       32'd20);

    // Push+pop at count 2, then addr_clr alongside a pop
    addr_clr_a = 1'b1;
    ifc_a.mem_ready = 1'b0;
    step();
    addr_clr_a = 1'b0;
    set_a(6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 32'h11, 26'h0);
    step();
    set_a(6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 32'h22, 26'h0);
    step();
    check("sim_count2", 32'(count_a), 32'd2);
    set_a(6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 32'h33, 26'h0);
    ifc_a.mem_ready = 1'b1;
    step();
    ifc_a.in_valid = 1'b0;
    check("sim_pushpop_count", 32'(count_a),    32'd2);
    check("sim_pushpop_wdata", ifc_a.mem_wdata, 32'h2022_0022);
    addr_clr_a = 1'b1;
    step();
    addr_clr_a = 1'b0;
    check("sim_clrpop_addr",  ifc_a.mem_addr,  32'd0);
    check("sim_clrpop_count", 32'(count_a),    32'd1);
    check("sim_clrpop_wdata", ifc_a.mem_wdata, 32'h2022_0033);
    step();
    ifc_a.mem_ready = 1'b0;
    check("sim_drain_addr", ifc_a.mem_addr, 32'd4);

    // Address wrap on the 4-bit instance: 8, 12, 0
    ifc_b.mem_ready = 1'b1;
    ifc_b.in_opcode = 6'h02;
    ifc_b.in_target = 26'd1;
    ifc_b.in_valid  = 1'b1;
    step();
    check("wrap_w0_addr",  32'(ifc_b.mem_addr), 32'd8);
    check("wrap_w0_wdata", ifc_b.mem_wdata,     32'h0800_0001);
    ifc_b.in_target = 26'd2;
    step();
    check("wrap_w1_addr",  32'(ifc_b.mem_addr), 32'd12);
    ifc_b.in_target = 26'd3;
    step();
    ifc_b.in_valid = 1'b0;
    check("wrap_w2_addr",  32'(ifc_b.mem_addr), 32'd0);
    check("wrap_w2_wdata", ifc_b.mem_wdata,     32'h0800_0003);
    step();
    check("wrap_after_addr", 32'(ifc_b.mem_addr), 32'd4);
    check("wrap_after_count", 32'(count_b),       32'd0);

`ifdef ENC_RANGE_CHECK_EN
    set_a(6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 32'h0001_2345, 26'h0);
    step();
    ifc_a.in_valid = 1'b0;
    check("rc_reject_err",   32'(err_a),   32'd1);
    check("rc_reject_count", 32'(count_a), 32'd0);
    step();
    check("rc_err_pulse_end", 32'(err_a), 32'd0);
    set_a(6'h23, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'hFFFF_8000, 26'h0);
    step();
    ifc_a.in_valid = 1'b0;
    check("rc_accept_err",   32'(err_a),      32'd0);
    check("rc_accept_count", 32'(count_a),    32'd1);
    check("rc_accept_wdata", ifc_a.mem_wdata, 32'h8C00_8000);
    ifc_a.mem_ready = 1'b1;
    step();
    ifc_a.mem_ready = 1'b0;
    check("rc_drain_count", 32'(count_a), 32'd0);
`endif

    // Asynchronous reset with words queued
    for (int k = 0; k < 3; k++) begin
      set_a(6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 32'h41 + 32'(k), 26'h0);
      step();
    end
    ifc_a.in_valid = 1'b0;
    check("arst_pre_count", 32'(count_a), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count",    32'(count_a),         32'd0);
    check("arst_valid",    32'(ifc_a.mem_valid), 32'd0);
    check("arst_ready",    32'(ifc_a.in_ready),  32'd1);
    check("arst_addr",     ifc_a.mem_addr,       32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("arst_post_count", 32'(count_a),         32'd0);
    check("arst_post_valid", 32'(ifc_a.mem_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
